// File: rtl/chroni_line_scheduler.sv
// Per-line render sequencer for the double-buffered scanline pixel buffer.
// Issues one render command per playfield line on the scanline tick grid and flags lines late for display.
module chroni_line_scheduler #(
  parameter int LINES  = 240,
  parameter int LINE_W = 9,
  parameter int GUARD  = 16
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic              vga_scale,
  input  logic              frame_start,
  input  logic              render_start,
  input  logic              scanline_start,
  input  logic              mode_changed,
  output logic              render_req,
  output logic [LINE_W-1:0] render_line,
  output logic [10:0]       render_base,
  input  logic              render_ack,
  input  logic              render_done,
  output logic              frame_active,
  output logic              overrun,
  output logic [7:0]        overrun_count
);

  typedef enum logic [2:0] {
    IDLE, ARMED, ISSUE, WAIT_DONE, WAIT_SLOT, FRAME_DONE, DRAIN
  } state_t;

  localparam int GW = $clog2(GUARD + 1);
  localparam int CW = LINE_W + 1;
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES - 1);

  state_t            state, state_next;
  logic [LINE_W-1:0] line, line_next;
  logic              drain_acked, drain_acked_next;
  logic [2:0]        period;
  logic [11:0]       tick, tick_next;
  logic [11:0]       slot_thr;
  logic [11:0]       disp_thr;
  logic [CW-1:0]     disp_m;
  logic [CW-1:0]     done_next;
  logic [GW-1:0]     guard_cnt;
  logic              abort, start_frame, tick_inc, line_finished;
  logic              slot_adv, miss_check, overrun_hit;

  assign abort         = frame_start | mode_changed;
  assign start_frame   = (state == ARMED) && render_start && !abort;
  assign tick_inc      = scanline_start && (guard_cnt == '0) && (tick != 12'hFFF);
  assign tick_next     = tick + 12'(tick_inc);
  assign line_finished = (state == WAIT_DONE) && render_done;
  // Lines completed so far, counting a completion landing in this very cycle.
  assign done_next     = {1'b0, line} + CW'(line_finished);
  assign slot_adv      = line_finished && !abort && (line != LAST_LINE) && (line != '0);
  assign miss_check    = frame_active && tick_inc && (tick_next == disp_thr) && (disp_m < CW'(LINES));
  assign overrun_hit   = miss_check && (disp_m >= done_next);

  assign render_line = line;
  assign render_base = line[0] ? 11'd640 : 11'd0;

  // NOTE: every output and next-state value gets a default before the case, so no latches are inferred.
  always_comb begin
    state_next       = state;
    line_next        = line;
    drain_acked_next = drain_acked;
    render_req       = 1'b0;
    unique case (state)
      IDLE:       if (abort) state_next = ARMED;
      ARMED:      if (start_frame) begin
                    state_next = ISSUE;
                    line_next  = '0;
                  end
      ISSUE: begin
        render_req = 1'b1;
        if (abort) begin
          state_next       = DRAIN;
          drain_acked_next = render_ack;
        end else if (render_ack) begin
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (abort) begin
          state_next       = render_done ? ARMED : DRAIN;
          drain_acked_next = 1'b1;
        end else if (render_done) begin
          if (line == LAST_LINE) begin
            state_next = FRAME_DONE;
          end else begin
            line_next  = line + LINE_W'(1);
            state_next = WAIT_SLOT;
          end
        end
      end
      WAIT_SLOT: begin
        // Line n may only overwrite its half once line n-2 has finished displaying.
        if (abort) state_next = ARMED;
        else if ((line == LINE_W'(1)) || (tick >= slot_thr)) state_next = ISSUE;
      end
      FRAME_DONE: if (abort) state_next = ARMED;
      DRAIN: begin
        render_req = !drain_acked;
        if (!drain_acked) begin
          if (render_ack) drain_acked_next = 1'b1;
        end else if (render_done) begin
          state_next = ARMED;
        end
      end
      default:    state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, and every register is async-cleared.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      line          <= '0;
      drain_acked   <= 1'b0;
      period        <= '0;
      tick          <= '0;
      guard_cnt     <= '0;
      slot_thr      <= '0;
      disp_thr      <= '0;
      disp_m        <= '0;
      frame_active  <= 1'b0;
      overrun       <= 1'b0;
      overrun_count <= '0;
    end else begin
      state        <= state_next;
      line         <= line_next;
      drain_acked  <= drain_acked_next;
      frame_active <= (state_next == ISSUE) || (state_next == WAIT_DONE) || (state_next == WAIT_SLOT);
      overrun      <= overrun_hit;
      if (overrun_hit && (overrun_count != 8'hFF)) overrun_count <= overrun_count + 8'd1;
      if (start_frame) begin
        period    <= vga_scale ? 3'd4 : 3'd2;
        tick      <= '0;
        guard_cnt <= GW'(GUARD);
        slot_thr  <= 12'd2;
        disp_thr  <= 12'd2;
        disp_m    <= '0;
      end else begin
        tick <= tick_next;
        if (guard_cnt != '0) guard_cnt <= guard_cnt - GW'(1);
        if (slot_adv) slot_thr <= slot_thr + {9'd0, period};
        // The display grid keeps marching even when a line is late.
        if (miss_check) begin
          disp_m   <= disp_m + CW'(1);
          disp_thr <= disp_thr + {9'd0, period};
        end
      end
    end
  end

endmodule

// File: tb/tb_chroni_line_scheduler.sv
// Bench for chroni_line_scheduler: a renderer agent plus a tick/deadline model derived from
// the line display rules, driven by directed frames and then randomized frames.
module tb_chroni_line_scheduler;

  localparam int LINES  = 4;
  localparam int LINE_W = 9;
  localparam int GUARD  = 16;

  logic              sys_clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              vga_scale = 1'b0;
  logic              frame_start = 1'b0;
  logic              render_start = 1'b0;
  logic              scanline_start = 1'b0;
  logic              mode_changed = 1'b0;
  logic              render_req;
  logic [LINE_W-1:0] render_line;
  logic [10:0]       render_base;
  logic              render_ack = 1'b0;
  logic              render_done = 1'b0;
  logic              frame_active;
  logic              overrun;
  logic [7:0]        overrun_count;

  int n_cmp = 0;
  int n_bad = 0;

  chroni_line_scheduler #(.LINES(LINES), .LINE_W(LINE_W), .GUARD(GUARD)) dut (
    .sys_clk        (sys_clk),
    .reset_n        (reset_n),
    .vga_scale      (vga_scale),
    .frame_start    (frame_start),
    .render_start   (render_start),
    .scanline_start (scanline_start),
    .mode_changed   (mode_changed),
    .render_req     (render_req),
    .render_line    (render_line),
    .render_base    (render_base),
    .render_ack     (render_ack),
    .render_done    (render_done),
    .frame_active   (frame_active),
    .overrun        (overrun),
    .overrun_count  (overrun_count)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model state: tick count, display deadlines, lines done
  int cyc = 0;
  int p_m = 2;
  int t_m = 0;
  int rs_cyc = -100000;
  bit frame_on = 0;
  int disp_m = 0;
  int done_cnt = 0;
  int exp_line = 0;
  int ovc_m = 0;
  bit exp_ov = 0;
  int ov_pulses = 0;
  int issue_t [LINES];
  // Renderer agent and scanline source
  bit busy = 0;
  int done_timer = 0;
  bit req_seen = 0;
  int ack_wait = 0;
  bit ack_en = 1;
  int ack_delay = 1;
  int done_delay [LINES];
  int idle_wait = 0;
  logic [LINE_W-1:0] held_line;
  logic [10:0] held_base;
  bit sl_en = 0;
  bit sl_force = 0;
  int sl_period = 100;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit slot_ok(input int k);
    return (k <= 1) || (t_m >= 2 + p_m * (k - 1));
  endfunction

  task automatic model_reset();
    t_m = 0; rs_cyc = -100000; frame_on = 0; disp_m = 0; done_cnt = 0; exp_line = 0;
    ovc_m = 0; busy = 0; done_timer = 0; req_seen = 0; ack_wait = 0; idle_wait = 0;
    frame_start = 0; render_start = 0; mode_changed = 0; render_ack = 0; render_done = 0;
    scanline_start = 0;
  endtask

  // One clock: drive agent + scanline, advance the model at the edge, then check outputs.
  task automatic step();
    bit acked;
    bit abort;
    scanline_start = sl_force || (sl_en && ((cyc % sl_period) == sl_period - 1));
    render_ack  = 1'b0;
    render_done = 1'b0;
    if (render_req === 1'b1) begin
      if (!req_seen) begin
        req_seen  = 1;
        held_line = render_line;
        held_base = render_base;
        check("req_line", 32'(render_line), exp_line);
        check("req_base", 32'(render_base), (exp_line % 2 == 1) ? 640 : 0);
        check("req_after_prev_done", done_cnt, exp_line);
        check("req_slot_ready", 32'(slot_ok(exp_line)), 1);
        if (exp_line < LINES) issue_t[exp_line] = t_m;
      end else begin
        check("req_line_stable", 32'(render_line), 32'(held_line));
        check("req_base_stable", 32'(render_base), 32'(held_base));
      end
      if (ack_en && ack_wait >= ack_delay) render_ack = 1'b1;
      else ack_wait++;
    end
    if (busy && done_timer == 0 && !scanline_start) render_done = 1'b1;

    @(posedge sys_clk);
    acked  = render_ack;
    abort  = frame_start | mode_changed;
    exp_ov = 0;
    if (render_start && !abort) begin
      t_m = 0; rs_cyc = cyc; frame_on = 1; disp_m = 0; done_cnt = 0; exp_line = 0;
      p_m = vga_scale ? 4 : 2;
      for (int i = 0; i < LINES; i++) issue_t[i] = -1;
    end else begin
      if (render_done) begin
        done_cnt++;
        busy = 0;
      end
      if (scanline_start && (cyc - rs_cyc > GUARD) && t_m < 4095) begin
        t_m++;
        if (frame_on && disp_m < LINES && t_m == 2 + p_m * disp_m) begin
          exp_ov = (done_cnt <= disp_m);
          if (exp_ov && ovc_m < 255) ovc_m++;
          disp_m++;
        end
      end
      if (abort || done_cnt == LINES) frame_on = 0;
    end
    if (acked) begin
      busy = 1;
      done_timer = done_delay[exp_line % LINES];
      exp_line++;
      req_seen = 0;
      ack_wait = 0;
    end else if (busy && !render_done && done_timer > 0) begin
      done_timer--;
    end

    #1;
    if (acked) check("req_drop_after_ack", 32'(render_req), 0);
    check("overrun", 32'(overrun), 32'(exp_ov));
    check("overrun_count", 32'(overrun_count), ovc_m);
    check("frame_active", 32'(frame_active), 32'(frame_on));
    if (overrun === 1'b1) ov_pulses++;
    if (frame_on && render_req === 1'b0 && !busy && exp_line < LINES &&
        done_cnt == exp_line && slot_ok(exp_line)) begin
      idle_wait++;
      check("issue_latency", 32'(idle_wait <= 3), 1);
    end else begin
      idle_wait = 0;
    end
    frame_start = 0; render_start = 0; mode_changed = 0; sl_force = 0;
    cyc++;
  endtask

  task automatic start_frame(input bit scale, input bit use_mode);
    vga_scale = scale;
    if (use_mode) mode_changed = 1'b1;
    else frame_start = 1'b1;
    step();
    render_start = 1'b1;
    step();
  endtask

  task automatic wait_frame(input int budget);
    int k;
    k = 0;
    while ((frame_on || busy) && k < budget) begin
      step();
      k++;
    end
    check("frame_complete", {30'd0, frame_on, busy}, 0);
  endtask

  initial begin
    int k;
    for (int i = 0; i < LINES; i++) begin
      done_delay[i] = 20;
      issue_t[i] = -1;
    end
    model_reset();
    repeat (2) @(posedge sys_clk);
    #2 reset_n = 1'b1;
    @(posedge sys_clk);
    #1;
    check("rst_req", 32'(render_req), 0);
    check("rst_line", 32'(render_line), 0);
    check("rst_base", 32'(render_base), 0);
    check("rst_frame_active", 32'(frame_active), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_overrun_count", 32'(overrun_count), 0);

    // Normal frame, 2 scanlines per line
    sl_en = 1; sl_period = 100; ack_delay = 1; ack_en = 1;
    start_frame(1'b0, 1'b0);
    wait_frame(5000);
    check("p2_line2_at_T", issue_t[2], 4);
    check("p2_line3_at_T", issue_t[3], 6);
    check("p2_no_overrun", 32'(overrun_count), 0);

    // Normal frame, 4 scanlines per line
    start_frame(1'b1, 1'b0);
    wait_frame(5000);
    check("p4_line2_at_T", issue_t[2], 6);
    check("p4_line3_at_T", issue_t[3], 10);

    // Line 2 finishes after its display start
    done_delay[2] = 300;
    ov_pulses = 0;
    start_frame(1'b0, 1'b0);
    wait_frame(5000);
    check("late_overrun_pulses", ov_pulses, 1);
    check("late_overrun_count", 32'(overrun_count), 1);
    done_delay[2] = 20;

    // Ack withheld on line 1, then frame_start forces a drain
    start_frame(1'b0, 1'b0);
    k = 0;
    while (!(busy && exp_line == 1) && k < 200) begin step(); k++; end
    ack_en = 0;
    k = 0;
    while (render_req !== 1'b1 && k < 200) begin step(); k++; end
    check("hold_req_raised", 32'(render_req), 1);
    repeat (3) step();
    frame_start = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      check("hold_req", 32'(render_req), 1);
      check("hold_line", 32'(render_line), 1);
      check("hold_base", 32'(render_base), 640);
      step();
    end
    check("abort_frame_active", 32'(frame_active), 0);
    ack_en = 1;
    k = 0;
    while ((render_req !== 1'b0 || busy) && k < 500) begin step(); k++; end
    check("drain_complete", {30'd0, render_req, busy}, 0);
    render_start = 1'b1;
    step();
    check("rearm_req", 32'(render_req), 1);
    check("rearm_line", 32'(render_line), 0);
    check("rearm_base", 32'(render_base), 0);
    wait_frame(5000);

    // Asynchronous reset while waiting for a line to complete
    start_frame(1'b0, 1'b0);
    k = 0;
    while (!busy && k < 200) begin step(); k++; end
    reset_n = 1'b0;
    #1;
    check("arst_req", 32'(render_req), 0);
    check("arst_frame_active", 32'(frame_active), 0);
    check("arst_overrun", 32'(overrun), 0);
    check("arst_overrun_count", 32'(overrun_count), 0);
    model_reset();
    @(posedge sys_clk);
    #2 reset_n = 1'b1;

    // Guard window: coincident and +10 scanlines must not count
    sl_en = 0;
    vga_scale = 1'b0;
    frame_start = 1'b1;
    step();
    render_start = 1'b1;
    sl_force = 1;
    step();
    repeat (9) step();
    sl_force = 1;
    step();
    k = 0;
    while (done_cnt < 2 && k < 500) begin step(); k++; end
    check("guard_lines01_done", done_cnt, 2);
    for (int i = 0; i < 3; i++) begin
      sl_force = 1;
      step();
      repeat (4) step();
    end
    check("guard_no_issue_T3", 32'(render_req), 0);
    check("guard_exp_line_T3", exp_line, 2);
    sl_force = 1;
    step();
    repeat (6) step();
    check("guard_line2_at_T4", issue_t[2], 4);
    check("guard_line2_acked", exp_line, 3);
    sl_en = 1;
    wait_frame(5000);

    // Randomized frames: scanline rate, ack latency and render time all vary
    for (int f = 0; f < 6; f++) begin
      sl_period = $urandom_range(40, 120);
      ack_delay = $urandom_range(0, 4);
      for (int i = 0; i < LINES; i++) done_delay[i] = $urandom_range(5, 2 * sl_period);
      start_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_frame(12000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
